// File: rtl/rr_fifo_aggregator_if.sv
// Bus bundle for rr_fifo_aggregator: per-channel write side, arbiter
// control/observation, and the merged valid/ready output stream.
interface rr_fifo_aggregator_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]            i_write;
  logic [CHANNELS*DATA_WIDTH-1:0] i_wr_data;
  logic [CHANNELS-1:0]            o_wr_full;
  logic [CHANNELS-1:0]            o_drop;
  logic                           i_block_arb;
  logic [CHANNELS-1:0]            o_gnt;
  logic                           o_valid;
  logic [ID_W+DATA_WIDTH-1:0]     o_data;
  logic                           i_ready;

  // Producer/consumer side of the block.
  modport master (
    output i_write, i_wr_data, i_block_arb, i_ready,
    input  o_wr_full, o_drop, o_gnt, o_valid, o_data
  );

  // The aggregator itself.
  modport slave (
    input  i_write, i_wr_data, i_block_arb, i_ready,
    output o_wr_full, o_drop, o_gnt, o_valid, o_data
  );
endinterface

// File: rtl/rr_fifo_aggregator.sv
// N-channel merge stage: one input FIFO per channel, a round-robin arbiter
// with burst quanta draining them into a shared show-ahead output FIFO whose
// words carry the source channel ID in the upper bits.
module rr_fifo_aggregator #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IN_DEPTH   = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int MAX_BURST  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rr_fifo_aggregator_if.slave  bus
);
  localparam int ID_W   = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = IN_AW + 1;
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = OUT_AW + 1;
  localparam int BW     = $clog2(MAX_BURST + 1);
  localparam int OUT_W  = ID_W + DATA_WIDTH;

  // Input FIFO state
  logic [DATA_WIDTH-1:0] in_mem  [CHANNELS][IN_DEPTH];
  logic [IN_AW-1:0]      in_wptr [CHANNELS];
  logic [IN_AW-1:0]      in_rptr [CHANNELS];
  logic [IN_CW-1:0]      in_cnt  [CHANNELS];
  logic [CHANNELS-1:0]   in_full, in_push, req, drop_q;

  // Arbiter state and decision
  logic [ID_W-1:0]       last_gnt, owner, gnt_id;
  logic                  owner_valid, gnt_valid, found;
  logic [BW-1:0]         burst_cnt;
  logic [CHANNELS-1:0]   gnt;

  // Output FIFO state
  logic [OUT_W-1:0]      out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0]     out_wptr, out_rptr;
  logic [OUT_CW-1:0]     out_cnt;
  logic                  out_space, out_pop;

  // Per-channel flags from registered counts; a same-cycle pop never admits a write.
  always_comb begin
    // NOTE: every variable driven here gets a value on every path, otherwise
    // synthesis infers a latch.
    in_full = '0;
    in_push = '0;
    req     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_full[c] = (in_cnt[c] == IN_CW'(IN_DEPTH));
      req[c]     = (in_cnt[c] != '0);
      in_push[c] = bus.i_write[c] & ~in_full[c];
    end
  end

  // Input FIFO pointers/counts and the registered drop pulse.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        in_wptr[c] <= '0;
        in_rptr[c] <= '0;
        in_cnt[c]  <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_push[c]) in_wptr[c] <= in_wptr[c] + IN_AW'(1);
        if (gnt[c])     in_rptr[c] <= in_rptr[c] + IN_AW'(1);
        case ({in_push[c], gnt[c]})
          2'b10:   in_cnt[c] <= in_cnt[c] + IN_CW'(1);
          2'b01:   in_cnt[c] <= in_cnt[c] - IN_CW'(1);
          default: in_cnt[c] <= in_cnt[c];
        endcase
      end
      drop_q <= bus.i_write & in_full;
    end
  end

  // Input FIFO storage writes.
  always_ff @(posedge i_clk) begin
    // NOTE: storage arrays carry no reset; the counts alone define validity,
    // so flushing is just clearing pointers and counts.
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_push[c]) in_mem[c][in_wptr[c]] <= bus.i_wr_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbitration: keep a burst owner while it has quota, else rotate from last_gnt+1.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    found     = 1'b0;
    gnt       = '0;
    if (!bus.i_block_arb && out_space && (|req)) begin
      gnt_valid = 1'b1;
      if (owner_valid && req[owner] && (burst_cnt < BW'(MAX_BURST))) begin
        gnt_id = owner;
      end else begin
        for (int i = 1; i <= CHANNELS; i++) begin
          if (!found && req[(int'(last_gnt) + i) % CHANNELS]) begin
            gnt_id = ID_W'((int'(last_gnt) + i) % CHANNELS);
            found  = 1'b1;
          end
        end
      end
      gnt[gnt_id] = 1'b1;
    end
  end

  // Arbiter history; the burst counter saturates when the owner is re-picked by rotation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_gnt    <= ID_W'(CHANNELS - 1);
      owner       <= '0;
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
    end else if (gnt_valid) begin
      last_gnt    <= gnt_id;
      owner       <= gnt_id;
      owner_valid <= 1'b1;
      if (!owner_valid || (owner != gnt_id)) burst_cnt <= BW'(1);
      else if (burst_cnt < BW'(MAX_BURST))    burst_cnt <= burst_cnt + BW'(1);
    end
  end

  // Output FIFO space/pop from the registered count.
  always_comb begin
    out_space = (out_cnt < OUT_CW'(OUT_DEPTH));
    out_pop   = (out_cnt != '0) & bus.i_ready;
  end

  // Output FIFO pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_wptr <= '0;
      out_rptr <= '0;
      out_cnt  <= '0;
    end else begin
      if (gnt_valid) out_wptr <= out_wptr + OUT_AW'(1);
      if (out_pop)   out_rptr <= out_rptr + OUT_AW'(1);
      case ({gnt_valid, out_pop})
        2'b10:   out_cnt <= out_cnt + OUT_CW'(1);
        2'b01:   out_cnt <= out_cnt - OUT_CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Output FIFO storage: tag the granted head word with its channel ID.
  always_ff @(posedge i_clk) begin
    if (gnt_valid) out_mem[out_wptr] <= {gnt_id, in_mem[gnt_id][in_rptr[gnt_id]]};
  end

  assign bus.o_wr_full = in_full;
  assign bus.o_drop    = drop_q;
  assign bus.o_gnt     = gnt;
  assign bus.o_valid   = (out_cnt != '0);
  assign bus.o_data    = out_mem[out_rptr];
endmodule

// File: tb/tb_rr_fifo_aggregator.sv
// Self-checking bench for rr_fifo_aggregator. Two instances share stimulus:
// dut1 with MAX_BURST=1 (checked throughout) and dut2 with MAX_BURST=2
// (checked for burst grant order).
module tb_rr_fifo_aggregator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  write = '0;
  logic [31:0] wr_data = '0;
  logic        blk = 1'b0;
  logic        ready = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;

  int          g1_q[$];
  int          g2_q[$];
  logic [9:0]  o1_q[$];

  always #5 clk = ~clk;

  rr_fifo_aggregator_if #(.CHANNELS(4), .DATA_WIDTH(8)) bus1();
  rr_fifo_aggregator_if #(.CHANNELS(4), .DATA_WIDTH(8)) bus2();

  assign bus1.i_write     = write;
  assign bus1.i_wr_data   = wr_data;
  assign bus1.i_block_arb = blk;
  assign bus1.i_ready     = ready;
  assign bus2.i_write     = write;
  assign bus2.i_wr_data   = wr_data;
  assign bus2.i_block_arb = blk;
  assign bus2.i_ready     = ready;

  rr_fifo_aggregator #(.CHANNELS(4), .DATA_WIDTH(8), .IN_DEPTH(8), .OUT_DEPTH(4), .MAX_BURST(1))
    dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  rr_fifo_aggregator #(.CHANNELS(4), .DATA_WIDTH(8), .IN_DEPTH(8), .OUT_DEPTH(4), .MAX_BURST(2))
    dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  typedef struct {
    logic [3:0]  wr;
    logic [31:0] wd;
    logic        blk;
    logic [3:0]  e_gnt;
    logic        e_valid;
    logic [9:0]  e_data;
    logic [3:0]  e_full;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [3:0] oh);
    case (oh)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 99;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record grants and accepted output words of the current cycle (call at negedge).
  task automatic sample();
    if (bus1.o_gnt != 4'b0) g1_q.push_back(oh2id(bus1.o_gnt));
    if (bus2.o_gnt != 4'b0) g2_q.push_back(oh2id(bus2.o_gnt));
    if (bus1.o_valid && ready) o1_q.push_back(bus1.o_data);
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      sample();
      tick();
    end
  endtask

  task automatic clear_q();
    g1_q.delete();
    g2_q.delete();
    o1_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; write = '0; wr_data = '0; blk = 1'b0; ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    int exp2[12];
    exp2 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};

    // Single word latency, then blocked arbitration and a round-robin sweep.
    tbl[0]  = '{4'b0001, 32'h0000_00A0, 1'b0, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[1]  = '{4'b0000, 32'h0,         1'b0, 4'b0001, 1'b0, 10'h000, 4'b0000};
    tbl[2]  = '{4'b0000, 32'h0,         1'b0, 4'b0000, 1'b1, 10'h0A0, 4'b0000};
    tbl[3]  = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[4]  = '{4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[5]  = '{4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[6]  = '{4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[7]  = '{4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[8]  = '{4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 10'h000, 4'b0000};
    tbl[9]  = '{4'b0000, 32'h0,         1'b0, 4'b0010, 1'b0, 10'h000, 4'b0000};
    tbl[10] = '{4'b0000, 32'h0,         1'b0, 4'b0100, 1'b1, 10'h111, 4'b0000};
    tbl[11] = '{4'b0000, 32'h0,         1'b0, 4'b1000, 1'b1, 10'h212, 4'b0000};
    tbl[12] = '{4'b0000, 32'h0,         1'b0, 4'b0001, 1'b1, 10'h313, 4'b0000};
    tbl[13] = '{4'b0000, 32'h0,         1'b0, 4'b0000, 1'b1, 10'h010, 4'b0000};
    tbl[14] = '{4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 10'h000, 4'b0000};

    // ---- Reset state ----
    do_reset();
    @(negedge clk);
    check("reset gnt",   32'(bus1.o_gnt),     32'h0);
    check("reset valid", 32'(bus1.o_valid),   32'h0);
    check("reset full",  32'(bus1.o_wr_full), 32'h0);
    check("reset drop",  32'(bus1.o_drop),    32'h0);
    tick();

    // ---- Table-driven cycles ----
    for (int i = 0; i < 15; i++) begin
      write = tbl[i].wr; wr_data = tbl[i].wd; blk = tbl[i].blk; ready = 1'b1;
      @(negedge clk);
      check($sformatf("row%0d gnt", i),   32'(bus1.o_gnt),     32'(tbl[i].e_gnt));
      check($sformatf("row%0d valid", i), 32'(bus1.o_valid),   32'(tbl[i].e_valid));
      check($sformatf("row%0d full", i),  32'(bus1.o_wr_full), 32'(tbl[i].e_full));
      if (tbl[i].e_valid) check($sformatf("row%0d data", i), 32'(bus1.o_data), 32'(tbl[i].e_data));
      tick();
    end
    write = '0; blk = 1'b0;

    // ---- Burst order: 3 words per channel, MAX_BURST 1 and 2 ----
    do_reset();
    blk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      write = 4'b1111;
      wr_data = {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 8'(k)};
      tick();
    end
    write = '0; blk = 1'b0;
    clear_q();
    run(20);
    check("burst1 grant count", 32'(g1_q.size()), 32'd12);
    check("burst2 grant count", 32'(g2_q.size()), 32'd12);
    check("burst1 out count",   32'(o1_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < g1_q.size()) check($sformatf("mb1 grant %0d", i), 32'(g1_q[i]), 32'(i % 4));
      if (i < g2_q.size()) check($sformatf("mb2 grant %0d", i), 32'(g2_q[i]), 32'(exp2[i]));
      if (i < o1_q.size())
        check($sformatf("mb1 out %0d", i), 32'(o1_q[i]), 32'({2'(i % 4), 8'((i % 4) * 16 + i / 4)}));
    end

    // ---- Backpressure: i_ready low, continuous supply on ch2 ----
    do_reset();
    ready = 1'b0;
    clear_q();
    for (int k = 0; k < 6; k++) begin
      write = 4'b0100;
      wr_data = 32'(8'h50 + k) << 16;
      run(1);
    end
    write = '0;
    run(4);
    check("bp grants while stalled", 32'(g1_q.size()), 32'd4);
    @(negedge clk);
    check("bp gnt when out full", 32'(bus1.o_gnt),   32'h0);
    check("bp valid when stalled", 32'(bus1.o_valid), 32'h1);
    tick();
    ready = 1'b1;
    run(12);
    check("bp total grants", 32'(g1_q.size()), 32'd6);
    check("bp out count",    32'(o1_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < o1_q.size()) check($sformatf("bp out %0d", i), 32'(o1_q[i]), 32'({2'd2, 8'(8'h50 + i)}));
    @(negedge clk);
    check("bp drained valid", 32'(bus1.o_valid), 32'h0);
    tick();

    // ---- Overflow on ch1 ----
    do_reset();
    blk = 1'b1;
    for (int k = 0; k < 8; k++) begin
      write = 4'b0010;
      wr_data = 32'(8'h40 + k) << 8;
      @(negedge clk);
      if (k == 7) check("ovf full before 8th", 32'(bus1.o_wr_full), 32'h0);
      tick();
    end
    write = 4'b0010; wr_data = 32'hEE << 8;   // 9th word, arbitration blocked
    @(negedge clk);
    check("ovf full after 8", 32'(bus1.o_wr_full), 32'h2);
    check("ovf no drop yet",  32'(bus1.o_drop),    32'h0);
    tick();
    clear_q();
    write = 4'b0010; wr_data = 32'hEF << 8;   // 10th word alongside a pop
    blk = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("ovf drop 9th",        32'(bus1.o_drop),    32'h2);
    check("ovf pop gnt",         32'(bus1.o_gnt),     32'h2);
    check("ovf still full",      32'(bus1.o_wr_full), 32'h2);
    sample();
    tick();
    write = '0;
    @(negedge clk);
    check("ovf drop 10th",       32'(bus1.o_drop),    32'h2);
    check("ovf full after pop",  32'(bus1.o_wr_full), 32'h0);
    sample();
    tick();
    @(negedge clk);
    check("ovf drop cleared",    32'(bus1.o_drop),    32'h0);
    sample();
    tick();
    run(12);
    check("ovf out count", 32'(o1_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < o1_q.size()) check($sformatf("ovf out %0d", i), 32'(o1_q[i]), 32'({2'd1, 8'(8'h40 + i)}));

    // ---- Mid-stream reset flushes everything ----
    do_reset();
    ready = 1'b0;
    write = 4'b0001; wr_data = 32'h61; tick();
    write = 4'b0001; wr_data = 32'h62; tick();
    write = '0;
    run(3);
    blk = 1'b1;
    for (int k = 0; k < 8; k++) begin
      write = 4'b1000;
      wr_data = 32'(8'h70 + k) << 24;
      tick();
    end
    write = '0;
    @(negedge clk);
    check("pre-rst valid", 32'(bus1.o_valid),   32'h1);
    check("pre-rst full",  32'(bus1.o_wr_full), 32'h8);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; blk = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("post-rst valid", 32'(bus1.o_valid),   32'h0);
    check("post-rst gnt",   32'(bus1.o_gnt),     32'h0);
    check("post-rst full",  32'(bus1.o_wr_full), 32'h0);
    check("post-rst drop",  32'(bus1.o_drop),    32'h0);
    tick();
    clear_q();
    run(5);
    check("post-rst no grants",  32'(g1_q.size()), 32'd0);
    check("post-rst no outputs", 32'(o1_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
